// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// | mux_pkg : mode encodings and index helper for the N:1 stream multiplexer |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Modulo-n increment: n-1 wraps to 0.
   function automatic int unsigned idx_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// | rr_arbiter : combinational round-robin arbiter, priority starting at ptr  |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          grant_vld,
   output logic [SW-1:0] grant_idx
);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;

   // Rotating the doubled vector puts the channel at ptr in bit 0.
   assign w_dbl = {req, req};
   assign w_rot = N'(w_dbl >> ptr);

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            grant_vld = 1'b1;
            grant_idx = SW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_n_1_rr.sv
// ---------------------------------------------------------------------------
// | mux_n_1_rr : N-input W-bit valid/ready multiplexer, fixed or round-robin |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module mux_n_1_rr
   import mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 2,
   parameter int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_src,
   output logic           out_valid,
   input  logic           out_ready
);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_src_q,  out_src_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          rr_vld;
   logic [SW-1:0] rr_idx;
   logic          fix_vld;
   logic          grant_vld;
   logic [SW-1:0] grant_idx;
   logic          free;
   logic          load;
   logic [W-1:0]  grant_data;

   rr_arbiter #(
      .N  (N),
      .SW (SW)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant_vld (rr_vld),
      .grant_idx (rr_idx)
   );

   // An out-of-range sel matches no channel, so it never grants.
   always_comb begin
      fix_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel == SW'(i)) fix_vld = in_valid[i];
      end
   end

   assign grant_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
   assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
   assign free      = !out_valid_q || out_ready;
   assign load      = !rst && free && grant_vld;

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SW'(i)) begin
            in_ready[i] = load;
            grant_data  = in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_data_d  = grant_data;
         out_src_d   = grant_idx;
         out_valid_d = 1'b1;
         if (mode == MODE_RR) ptr_d = SW'(idx_next(int'(unsigned'(grant_idx)), N));
      end else if (free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_1_rr.sv
// ---------------------------------------------------------------------------
// | tb_mux_n_1_rr : directed bench for mux_n_1_rr (N=4 and N=3 instances)    |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_n_1_rr;

   logic       clk = 1'b0;
   logic       rst;

   logic [7:0] in_data4;
   logic [3:0] in_valid4, in_ready4;
   logic       mode4, out_valid4, out_ready4;
   logic [1:0] sel4, out_data4, out_src4;

   logic [5:0] in_data3;
   logic [2:0] in_valid3, in_ready3;
   logic       mode3, out_valid3, out_ready3;
   logic [1:0] sel3, out_data3, out_src3;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mux_n_1_rr #(.N(4), .W(2)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
      .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
      .out_src(out_src4), .out_valid(out_valid4), .out_ready(out_ready4)
   );

   mux_n_1_rr #(.N(3), .W(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
      .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Round-robin sources expected for all-valid and for {1,3}-valid phases.
   logic [1:0] exp_rr_all [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0] exp_rr_13  [4] = '{2'd3, 2'd1, 2'd3, 2'd1};

   initial begin
      in_data4  = {2'd3, 2'd2, 2'd1, 2'd0};
      in_data3  = {2'd2, 2'd1, 2'd0};
      in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;

      // Reset with requests present: nothing may be accepted.
      rst = 1'b1; mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'hF; out_ready4 = 1'b1;
      step(); step();
      check("rst_in_ready", 32'(in_ready4), 32'h0);
      check("rst_valid", 32'(out_valid4), 32'h0);
      check("rst_data",  32'(out_data4),  32'h0);
      check("rst_src",   32'(out_src4),   32'h0);

      // Fixed mode, sel=2.
      rst = 1'b0;
      #1;
      check("fix_in_ready0", 32'(in_ready4), 32'h4);
      step();
      check("fix_data", 32'(out_data4), 32'h2);
      check("fix_src",  32'(out_src4),  32'h2);
      check("fix_valid", 32'(out_valid4), 32'h1);
      check("fix_in_ready1", 32'(in_ready4), 32'h4);
      step();
      check("fix_in_ready2", 32'(in_ready4), 32'h4);

      // Round-robin, all valid, ptr starts at 0.
      mode4 = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("rr_all_src%0d", i), 32'(out_src4), 32'(exp_rr_all[i]));
         check($sformatf("rr_all_vld%0d", i), 32'(out_valid4), 32'h1);
      end

      // ptr is now 1; one load of channel 1 moves it to 2.
      in_valid4 = 4'b0010;
      #1;
      check("rr_ptr_prep_rdy", 32'(in_ready4), 32'h2);
      step();
      check("rr_ptr_prep_src", 32'(out_src4), 32'h1);

      in_valid4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr13_rdy%0d", i), 32'(in_ready4), 32'(4'b1 << exp_rr_13[i]));
         step();
         check($sformatf("rr13_src%0d", i), 32'(out_src4), 32'(exp_rr_13[i]));
         check($sformatf("rr13_data%0d", i), 32'(out_data4), 32'(exp_rr_13[i]));
      end

      // Back-pressure: held beat is src=1/data=1, ptr=2.
      out_ready4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_rdy%0d", i), 32'(in_ready4), 32'h0);
         step();
         check($sformatf("bp_hold%0d", i), {29'd0, out_valid4, out_src4}, {29'd0, 1'b1, 2'd1});
         check($sformatf("bp_data%0d", i), 32'(out_data4), 32'h1);
      end
      out_ready4 = 1'b1;
      #1;
      check("bp_release_rdy", 32'(in_ready4), 32'h8);
      step();
      check("bp_release", {29'd0, out_valid4, out_src4}, {29'd0, 1'b1, 2'd3});

      // Load channel 1 (ptr 0 -> 2), then stall and reset mid-transfer.
      #1;
      check("pre_rst_rdy", 32'(in_ready4), 32'h2);
      step();
      check("pre_rst_src", 32'(out_src4), 32'h1);
      out_ready4 = 1'b0; in_valid4 = 4'hF;
      step();
      rst = 1'b1;
      #1;
      check("midrst_rdy", 32'(in_ready4), 32'h0);
      step();
      check("midrst_out", {27'd0, out_valid4, out_data4, out_src4}, 32'h0);
      rst = 1'b0; out_ready4 = 1'b1;
      #1;
      check("rr_restart_rdy", 32'(in_ready4), 32'h1);
      step();
      check("rr_restart_src", 32'(out_src4), 32'h0);
      in_valid4 = 4'h0;

      // N=3: out-of-range sel never grants.
      in_valid3 = 3'b111; sel3 = 2'd1; out_ready3 = 1'b0;
      #1;
      check("n3_sel1_rdy", 32'(in_ready3), 32'h2);
      step();
      check("n3_load", {27'd0, out_valid3, out_data3, out_src3}, {27'd0, 1'b1, 2'd1, 2'd1});
      sel3 = 2'd3;
      #1;
      check("n3_sel3_rdy", 32'(in_ready3), 32'h0);
      step();
      check("n3_hold", 32'(out_valid3), 32'h1);
      out_ready3 = 1'b1;
      #1;
      check("n3_sel3_rdy_free", 32'(in_ready3), 32'h0);
      step();
      check("n3_drain", {27'd0, out_valid3, out_data3, out_src3}, {27'd0, 1'b0, 2'd1, 2'd1});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
